apb_mem_ws: RTL and testbench

APB_MEM_WS -- requirements
Module: apb_mem_ws

---
 rtl/apb_mem_pkg.sv | 16 +
 rtl/apb_mem_lane.sv | 22 ++
 rtl/apb_mem_ws.sv | 126 ++++++++++++
 tb/tb_apb_mem_ws.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_mem_pkg.sv
// Shared defaults and FSM state encoding for the wait-stated byte-lane memory.
package apb_mem_pkg;

  localparam int unsigned DefLaneWidth = 8;
  localparam int unsigned DefLanes     = 4;
  localparam int unsigned DefMemSize   = 256;
  localparam int unsigned DefRdWait    = 1;
  localparam int unsigned DefWrWait    = 0;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StWait = 2'd1;
  localparam state_t StDone = 2'd2;

endpackage

// File: rtl/apb_mem_lane.sv
// One byte lane of storage: single write port, registered read port.
module apb_mem_lane #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/apb_mem_ws.sv
// Byte-lane memory with configurable read/write wait states and a one-cycle
// ready pulse; out-of-range and conflicting requests complete with an error.
module apb_mem_ws
  import apb_mem_pkg::*;
#(
  parameter int unsigned LANE_WIDTH = DefLaneWidth,
  parameter int unsigned LANES      = DefLanes,
  parameter int unsigned MEM_SIZE   = DefMemSize,
  parameter int unsigned RD_WAIT    = DefRdWait,
  parameter int unsigned WR_WAIT    = DefWrWait,
  localparam int unsigned DW = LANE_WIDTH * LANES,
  localparam int unsigned AW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_rd,
  input  logic             mem_wr,
  input  logic [AW:0]      mem_address,
  input  logic [LANES-1:0] mem_be,
  input  logic [DW-1:0]    mem_data_in,
  output logic [DW-1:0]    mem_data_out,
  output logic             mem_ready,
  output logic             mem_err
);

  localparam logic [3:0] RdW     = 4'(RD_WAIT);
  localparam logic [3:0] WrW     = 4'(WR_WAIT);
  localparam logic [AW:0] SizeLim = (AW + 1)'(MEM_SIZE);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [AW-1:0]    addr_q;
  logic [LANES-1:0] be_q;
  logic [DW-1:0]    data_q;
  logic             wr_q, err_q, rvalid_q;

  logic             req, in_idle, cur_wr, cur_err;
  logic             enter_done, do_wr, do_rd;
  logic [3:0]       wait_n;
  logic [AW-1:0]    cur_addr;
  logic [LANES-1:0] cur_be;
  logic [DW-1:0]    cur_data, rdata;

  assign req     = mem_rd | mem_wr;
  assign in_idle = (state_q == StIdle);
  // A rd+wr conflict is treated as a write for latency, then suppressed by the error.
  assign wait_n  = mem_wr ? WrW : RdW;

  // With zero wait states the array is accessed on the sampling edge itself,
  // so the live request fields are used while idle.
  assign cur_wr   = in_idle ? mem_wr : wr_q;
  assign cur_err  = in_idle ? ((mem_rd & mem_wr) | (mem_address >= SizeLim)) : err_q;
  assign cur_addr = in_idle ? mem_address[AW-1:0] : addr_q;
  assign cur_be   = in_idle ? mem_be : be_q;
  assign cur_data = in_idle ? mem_data_in : data_q;

  assign enter_done = !rst && req &&
                      ((in_idle && (wait_n == 4'd0)) || (state_q == StWait && cnt_q == 4'd0));
  assign do_wr = enter_done & cur_wr & ~cur_err;
  assign do_rd = enter_done & ~cur_wr & ~cur_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (req) begin
          if (wait_n == 4'd0) begin
            state_d = StDone;
          end else begin
            state_d = StWait;
            cnt_d   = wait_n - 4'd1;
          end
        end
      end
      StWait: begin
        if (!req)               state_d = StIdle;
        else if (cnt_q == 4'd0) state_d = StDone;
        else                    cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= do_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (in_idle && req) begin
      addr_q <= mem_address[AW-1:0];
      be_q   <= mem_be;
      data_q <= mem_data_in;
      wr_q   <= mem_wr;
      err_q  <= cur_err;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    apb_mem_lane #(
      .WIDTH(LANE_WIDTH),
      .DEPTH(MEM_SIZE),
      .AW   (AW)
    ) u_lane (
      .clk  (clk),
      .we   (do_wr & cur_be[k]),
      .re   (do_rd),
      .addr (cur_addr),
      .wdata(cur_data[LANE_WIDTH*k +: LANE_WIDTH]),
      .rdata(rdata[LANE_WIDTH*k +: LANE_WIDTH])
    );
  end

  assign mem_ready    = (state_q == StDone);
  assign mem_err      = mem_ready & err_q;
  assign mem_data_out = rvalid_q ? rdata : '0;

endmodule

// File: tb/tb_apb_mem_ws.sv
// Directed bench for apb_mem_ws: default-parameter instance plus a RD_WAIT=3 instance.
module tb_apb_mem_ws;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  logic        rst, rd, wr, rdy, err;
  logic [8:0]  addr;
  logic [3:0]  be;
  logic [31:0] din, dout;

  logic        rst3, rd3, wr3, rdy3, err3;
  logic [8:0]  addr3;
  logic [3:0]  be3;
  logic [31:0] din3, dout3;

  apb_mem_ws dut (
    .clk         (clk),
    .rst         (rst),
    .mem_rd      (rd),
    .mem_wr      (wr),
    .mem_address (addr),
    .mem_be      (be),
    .mem_data_in (din),
    .mem_data_out(dout),
    .mem_ready   (rdy),
    .mem_err     (err)
  );

  apb_mem_ws #(.RD_WAIT(3)) dut3 (
    .clk         (clk),
    .rst         (rst3),
    .mem_rd      (rd3),
    .mem_wr      (wr3),
    .mem_address (addr3),
    .mem_be      (be3),
    .mem_data_in (din3),
    .mem_data_out(dout3),
    .mem_ready   (rdy3),
    .mem_err     (err3)
  );

  int sel = 0;
  logic        m_rdy, m_err;
  logic [31:0] m_dout;
  assign m_rdy  = (sel != 0) ? rdy3  : rdy;
  assign m_err  = (sel != 0) ? err3  : err;
  assign m_dout = (sel != 0) ? dout3 : dout;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic r, input logic w, input logic [8:0] a,
                         input logic [3:0] b, input logic [31:0] d);
    if (sel == 0) begin
      rd = r; wr = w; addr = a; be = b; din = d;
    end else begin
      rd3 = r; wr3 = w; addr3 = a; be3 = b; din3 = d;
    end
  endtask

  // Starts in an IDLE cycle, returns in the IDLE cycle after DONE.
  task automatic xfer(input logic r, input logic w, input logic [8:0] a, input logic [3:0] b,
                      input logic [31:0] d, output logic [31:0] q, output logic e,
                      output int n, output int t0);
    t0 = cyc_cnt;
    set_req(r, w, a, b, d);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!m_rdy && n < 40);
    if (!m_rdy) check("ready_timeout", {31'd0, m_rdy}, 32'd1);
    q = m_dout;
    e = m_err;
    set_req(1'b0, 1'b0, a, b, d);
    @(posedge clk); #1;
  endtask

  logic [31:0] q, model [64];
  logic        e;
  int          n, t, prev_t, prev_w;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rst3 = 1'b1;
    sel = 0; set_req(1'b0, 1'b0, 9'd0, 4'h0, 32'd0);
    sel = 1; set_req(1'b0, 1'b0, 9'd0, 4'h0, 32'd0);
    sel = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, rdy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_data", dout, 32'd0);
    check("rst3_ready", {31'd0, rdy3}, 32'd0);
    rst = 1'b0; rst3 = 1'b0;
    @(posedge clk); #1;

    xfer(1'b0, 1'b1, 9'd5, 4'hF, 32'hA5A5_1234, q, e, n, t);
    check("wr5_latency", n, 32'd1);
    check("wr5_err", {31'd0, e}, 32'd0);
    xfer(1'b1, 1'b0, 9'd5, 4'hF, 32'd0, q, e, n, t);
    check("rd5_latency", n, 32'd2);
    check("rd5_data", q, 32'hA5A5_1234);
    check("rd5_err", {31'd0, e}, 32'd0);
    check("data_zero_after_done", dout, 32'd0);

    xfer(1'b0, 1'b1, 9'd9, 4'hF, 32'd0, q, e, n, t);
    xfer(1'b0, 1'b1, 9'd9, 4'b0101, 32'hFFFF_FFFF, q, e, n, t);
    xfer(1'b1, 1'b0, 9'd9, 4'hF, 32'd0, q, e, n, t);
    check("be0101_data", q, 32'h00FF_00FF);

    xfer(1'b0, 1'b1, 9'd0, 4'hF, 32'hDEAD_BEEF, q, e, n, t);
    xfer(1'b1, 1'b0, 9'd256, 4'hF, 32'd0, q, e, n, t);
    check("oor_err", {31'd0, e}, 32'd1);
    check("oor_data", q, 32'd0);
    check("oor_latency", n, 32'd2);
    xfer(1'b1, 1'b0, 9'd0, 4'hF, 32'd0, q, e, n, t);
    check("addr0_kept", q, 32'hDEAD_BEEF);

    xfer(1'b0, 1'b1, 9'd3, 4'hF, 32'h1234_5678, q, e, n, t);
    xfer(1'b1, 1'b1, 9'd3, 4'hF, 32'h1111_1111, q, e, n, t);
    check("rdwr_err", {31'd0, e}, 32'd1);
    check("rdwr_latency", n, 32'd1);
    check("rdwr_data", q, 32'd0);
    xfer(1'b1, 1'b0, 9'd3, 4'hF, 32'd0, q, e, n, t);
    check("rdwr_no_write", q, 32'h1234_5678);

    xfer(1'b0, 1'b1, 9'd3, 4'h0, 32'hFFFF_FFFF, q, e, n, t);
    check("be0_err", {31'd0, e}, 32'd0);
    check("be0_latency", n, 32'd1);
    xfer(1'b1, 1'b0, 9'd3, 4'hF, 32'd0, q, e, n, t);
    check("be0_unchanged", q, 32'h1234_5678);

    // Request withdrawn during WAIT.
    set_req(1'b1, 1'b0, 9'd5, 4'hF, 32'd0);
    @(posedge clk); #1;
    check("drop_wait_ready", {31'd0, rdy}, 32'd0);
    set_req(1'b0, 1'b0, 9'd5, 4'hF, 32'd0);
    @(posedge clk); #1;
    check("drop_ready_c2", {31'd0, rdy}, 32'd0);
    @(posedge clk); #1;
    check("drop_ready_c3", {31'd0, rdy}, 32'd0);
    check("drop_data", dout, 32'd0);

    // Address changed after sampling is ignored.
    set_req(1'b1, 1'b0, 9'd5, 4'hF, 32'd0);
    @(posedge clk); #1;
    set_req(1'b1, 1'b0, 9'd9, 4'hF, 32'd0);
    @(posedge clk); #1;
    check("late_addr_ready", {31'd0, rdy}, 32'd1);
    check("late_addr_data", dout, 32'hA5A5_1234);
    set_req(1'b0, 1'b0, 9'd0, 4'h0, 32'd0);
    @(posedge clk); #1;

    // RD_WAIT=3 instance: reset in the second WAIT cycle aborts the read.
    sel = 1;
    xfer(1'b0, 1'b1, 9'd7, 4'hF, 32'h0BAD_F00D, q, e, n, t);
    check("w3_wr_latency", n, 32'd1);
    set_req(1'b1, 1'b0, 9'd7, 4'hF, 32'd0);
    @(posedge clk); #1;
    check("w3_wait1_ready", {31'd0, rdy3}, 32'd0);
    @(posedge clk); #1;
    rst3 = 1'b1;
    @(posedge clk); #1;
    rst3 = 1'b0;
    check("w3_abort_ready", {31'd0, rdy3}, 32'd0);
    check("w3_abort_err", {31'd0, err3}, 32'd0);
    check("w3_abort_data", dout3, 32'd0);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!rdy3 && n < 40);
    check("w3_rd_latency", n, 32'd4);
    check("w3_rd_data", dout3, 32'h0BAD_F00D);
    set_req(1'b0, 1'b0, 9'd0, 4'h0, 32'd0);
    @(posedge clk); #1;

    // Back-to-back random traffic on addresses 32..47 against a model.
    sel = 0;
    prev_t = 0; prev_w = 0;
    for (int i = 0; i < 16; i++) begin
      model[i] = $urandom;
      xfer(1'b0, 1'b1, 9'(32 + i), 4'hF, model[i], q, e, n, t);
      if (i > 0) check("b2b_period_fill", t - prev_t, 32'(prev_w + 2));
      prev_t = t; prev_w = 0;
    end
    for (int i = 0; i < 24; i++) begin
      logic        w_op;
      logic [3:0]  bb;
      logic [31:0] dd;
      int          ai;
      w_op = 1'($urandom_range(1));
      ai   = $urandom_range(15);
      bb   = 4'($urandom);
      dd   = $urandom;
      xfer(~w_op, w_op, 9'(32 + ai), bb, dd, q, e, n, t);
      check("b2b_period", t - prev_t, 32'(prev_w + 2));
      prev_t = t;
      if (w_op) begin
        for (int k = 0; k < 4; k++) if (bb[k]) model[ai][8*k +: 8] = dd[8*k +: 8];
        check("b2b_wr_latency", n, 32'd1);
        prev_w = 0;
      end else begin
        check("b2b_rd_latency", n, 32'd2);
        check("b2b_rd_data", q, model[ai]);
        prev_w = 1;
      end
      check("b2b_err", {31'd0, e}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
